counter_seq: RTL and testbench

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_seq_if.sv | 37 +++
 rtl/counter_seq.sv | 202 ++++++++++++++++++++
 tb/tb_counter_seq.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_if.sv
// ---------------------------------------------------------------------------
// counter_seq_if
//
// Command handshake between an upstream controller and counter_seq.
//
// Signals
//   CmdValid  upstream -> seq   command offered this cycle
//   CmdReady  seq -> upstream   sequencer can take a command this cycle
//   CmdOp     upstream -> seq   2'b00 NOP, 2'b01 LOAD, 2'b10 UP, 2'b11 DOWN
//   CmdArg    upstream -> seq   LOAD value, or step count for UP/DOWN
//
// Modports
//   master : the command source
//   slave  : counter_seq
// ---------------------------------------------------------------------------
interface counter_seq_if #(
    parameter int WIDTH = 8
);
    logic             CmdValid;
    logic             CmdReady;
    logic [1:0]       CmdOp;
    logic [WIDTH-1:0] CmdArg;

    modport master (
        output CmdValid,
        output CmdOp,
        output CmdArg,
        input  CmdReady
    );

    modport slave (
        input  CmdValid,
        input  CmdOp,
        input  CmdArg,
        output CmdReady
    );
endinterface

// File: rtl/counter_seq.sv
// ---------------------------------------------------------------------------
// counter_seq
//
// Sequences a downstream up/down counter (Enable/Load/UpDn/Data) from
// single-word commands: LOAD a value, step UP or DOWN n times, or NOP.
// All outputs are Moore decodes of registered state; there is no
// combinational path from the command inputs to any output.
//
// Ports
//   Clock    in   sole clock, rising edge
//   Reset    in   synchronous, active-high
//   cmd      slave modport of counter_seq_if (CmdValid/CmdReady/CmdOp/CmdArg)
//   Enable   out  downstream counter enable
//   Load     out  downstream counter load strobe
//   UpDn     out  downstream direction, 1 = increment
//   Data     out  downstream load value; holds the last loaded value
//   Busy     out  command in progress
//   Done     out  one-cycle pulse on command completion
//   Sat      out  one-cycle pulse (with Done) when stepping was cut short
//
// Build option
//   COUNTER_SEQ_SAT_EN  when defined, a shadow copy of the downstream count
//                       is kept and any step that would wrap it is withheld;
//                       the command then finishes early with Sat=1.
//                       When undefined, steps are always issued in full and
//                       Sat is tied low.
// ---------------------------------------------------------------------------
module counter_seq #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    counter_seq_if.slave     cmd,
    output logic             Enable,
    output logic             Load,
    output logic             UpDn,
    output logic [WIDTH-1:0] Data,
    output logic             Busy,
    output logic             Done,
    output logic             Sat
);

    // state | meaning
    // ------+---------------------------------------------------------------
    // IDLE  | waiting for a command, CmdReady=1
    // LOAD  | one cycle driving Enable=1 Load=1 Data=captured value
    // STEP  | one downstream step per cycle until the step counter expires
    // DONE  | one cycle with Done=1, outputs quiet, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_up_q, dir_up_d;

    // Set when the step about to be issued would wrap the downstream count.
    logic             wrap;

`ifdef COUNTER_SEQ_SAT_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             sat_q, sat_d;

    assign wrap = dir_up_q ? (shadow_q == {WIDTH{1'b1}}) : (shadow_q == '0);
`else
    assign wrap = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        data_d     = data_q;
        dir_up_d   = dir_up_q;
`ifdef COUNTER_SEQ_SAT_EN
        shadow_d   = shadow_q;
        sat_d      = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd.CmdValid) begin
                    unique case (cmd.CmdOp)
                        OP_LOAD: begin
                            // Captured at acceptance so Data is already
                            // valid in the LOAD cycle and holds afterwards.
                            data_d  = cmd.CmdArg;
                            state_d = LOAD;
                        end
                        OP_UP, OP_DOWN: begin
                            dir_up_d   = (cmd.CmdOp == OP_UP);
                            step_cnt_d = cmd.CmdArg;
                            state_d    = (cmd.CmdArg != '0) ? STEP : DONE;
                        end
                        OP_NOP: begin
                            state_d = DONE;
                        end
                        default: begin
                            state_d = DONE;
                        end
                    endcase
                end
            end

            LOAD: begin
`ifdef COUNTER_SEQ_SAT_EN
                shadow_d = data_q;
`endif
                state_d = DONE;
            end

            STEP: begin
                if (wrap) begin
                    // Step withheld: finish now and flag the early stop.
                    step_cnt_d = '0;
                    state_d    = DONE;
`ifdef COUNTER_SEQ_SAT_EN
                    sat_d      = 1'b1;
`endif
                end else begin
                    // Down-counter with terminal count at 1: the cycle that
                    // sees 1 issues the last step.
                    step_cnt_d = step_cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    if (step_cnt_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                        state_d = DONE;
                    end
`ifdef COUNTER_SEQ_SAT_EN
                    shadow_d = dir_up_q ? shadow_q + {{(WIDTH-1){1'b0}}, 1'b1}
                                        : shadow_q - {{(WIDTH-1){1'b0}}, 1'b1};
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            data_q     <= '0;
            dir_up_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            data_q     <= data_d;
            dir_up_q   <= dir_up_d;
        end
    end

`ifdef COUNTER_SEQ_SAT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            shadow_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            sat_q    <= sat_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Moore output decode
    // -----------------------------------------------------------------------
    assign cmd.CmdReady = (state_q == IDLE);
    assign Busy         = (state_q != IDLE);
    assign Done         = (state_q == DONE);
    assign Load         = (state_q == LOAD);
    assign Enable       = (state_q == LOAD) || ((state_q == STEP) && !wrap);
    // Direction is qualified by Enable so a withheld step shows no direction.
    assign UpDn         = (state_q == STEP) && !wrap && dir_up_q;
    assign Data         = data_q;

`ifdef COUNTER_SEQ_SAT_EN
    assign Sat = sat_q;
`else
    assign Sat = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq.sv
// ---------------------------------------------------------------------------
// tb_counter_seq
//
// Directed bench for counter_seq. Each accepted command is expanded into a
// queue of expected per-cycle output words from the command rules; a single
// compare process pops one word per cycle (idle expectation when empty).
// A small downstream counter driven by the DUT outputs, plus per-command
// cycle counters, are checked against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_counter_seq;

    localparam int WIDTH = 8;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic             Clock;
    logic             Reset;
    logic             Enable;
    logic             Load;
    logic             UpDn;
    logic [WIDTH-1:0] Data;
    logic             Busy;
    logic             Done;
    logic             Sat;

    counter_seq_if #(.WIDTH(WIDTH)) cmd_if ();

    counter_seq #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .cmd    (cmd_if),
        .Enable (Enable),
        .Load   (Load),
        .UpDn   (UpDn),
        .Data   (Data),
        .Busy   (Busy),
        .Done   (Done),
        .Sat    (Sat)
    );

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       en;
        logic       ld;
        logic       updn;
        logic       done;
        logic       sat;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_last;   // last loaded value (Data outside LOAD)
    logic [7:0] model_cnt;    // what the downstream counter must hold
    logic [7:0] ds_cnt;       // downstream counter driven by the DUT
    bit         chk_en;
    int         n_tests;
    int         n_fail;
    int         cnt_en, cnt_busy, cnt_done, cnt_sat;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    always @(posedge Clock) begin
        if (Reset)
            ds_cnt <= 8'h00;
        else if (Enable)
            ds_cnt <= Load ? Data : (UpDn ? ds_cnt + 8'd1 : ds_cnt - 8'd1);
    end

    function automatic exp_t mk(input logic busy, input logic en, input logic ld,
                                input logic updn, input logic done, input logic sat,
                                input logic [7:0] d);
        exp_t r;
        r.ready = ~busy;
        r.busy  = busy;
        r.en    = en;
        r.ld    = ld;
        r.updn  = updn;
        r.done  = done;
        r.sat   = sat;
        r.data  = d;
        return r;
    endfunction

    // Per-cycle compare against the model queue.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge Clock);
            if (chk_en) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else                  e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_last);
                a = {cmd_if.CmdReady, Busy, Enable, Load, UpDn, Done, Sat, Data};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_cmp t=%0t got rdy=%b busy=%b en=%b ld=%b updn=%b done=%b sat=%b data=%h, required rdy=%b busy=%b en=%b ld=%b updn=%b done=%b sat=%b data=%h",
                             $time, a.ready, a.busy, a.en, a.ld, a.updn, a.done, a.sat, a.data,
                             e.ready, e.busy, e.en, e.ld, e.updn, e.done, e.sat, e.data);
                end
                if (Enable) cnt_en++;
                if (Busy)   cnt_busy++;
                if (Done)   cnt_done++;
                if (Sat)    cnt_sat++;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic clr_counts();
        cnt_en   = 0;
        cnt_busy = 0;
        cnt_done = 0;
        cnt_sat  = 0;
    endtask

    // Expand one accepted command into expected per-cycle outputs.
    task automatic build(input logic [1:0] op, input logic [7:0] arg, output int m);
        int n0;
        bit sat;
        n0  = exp_q.size();
        sat = 1'b0;
        case (op)
            OP_LOAD: begin
                exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, arg));
                model_last = arg;
                model_cnt  = arg;
            end
            OP_UP, OP_DOWN: begin
                for (int i = 0; i < int'(arg); i++) begin
`ifdef COUNTER_SEQ_SAT_EN
                    if ((op == OP_UP && model_cnt == 8'hFF) || (op == OP_DOWN && model_cnt == 8'h00)) begin
                        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_last));
                        sat = 1'b1;
                        break;
                    end
`endif
                    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, op == OP_UP, 1'b0, 1'b0, model_last));
                    model_cnt = (op == OP_UP) ? model_cnt + 8'd1 : model_cnt - 8'd1;
                end
            end
            default: ;
        endcase
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, sat, model_last));
        m = exp_q.size() - n0;
    endtask

    // Called #1 after a posedge in an idle cycle; returns #1 after the
    // posedge that ends the command's DONE cycle (i.e. in the next idle cycle).
    task automatic issue(input logic [1:0] op, input logic [7:0] arg, input bit hold);
        int m;
        clr_counts();
        cmd_if.CmdValid = 1'b1;
        cmd_if.CmdOp    = op;
        cmd_if.CmdArg   = arg;
        @(posedge Clock); #1;
        build(op, arg, m);
        for (int i = 0; i < m; i++) begin
            if (hold) begin
                cmd_if.CmdValid = 1'b1;
                cmd_if.CmdOp    = 2'($urandom_range(0, 3));
                cmd_if.CmdArg   = 8'($urandom_range(0, 255));
            end else begin
                cmd_if.CmdValid = 1'b0;
            end
            @(posedge Clock); #1;
        end
        cmd_if.CmdValid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        model_last = 8'h00;
        model_cnt  = 8'h00;
        clr_counts();

        // Reset with a command offered: reset must win.
        Reset           = 1'b1;
        cmd_if.CmdValid = 1'b1;
        cmd_if.CmdOp    = OP_LOAD;
        cmd_if.CmdArg   = 8'h77;
        repeat (3) @(posedge Clock);
        #1;
        Reset           = 1'b0;
        cmd_if.CmdValid = 1'b0;
        chk_en          = 1'b1;
        check("rst_ready", int'(cmd_if.CmdReady), 1);
        check("rst_busy",  int'(Busy),   0);
        check("rst_data",  int'(Data),   0);
        check("rst_en",    int'(Enable), 0);
        check("rst_sat",   int'(Sat),    0);
        @(posedge Clock); #1;

        // LOAD 0x5A
        issue(OP_LOAD, 8'h5A, 1'b0);
        check("load_en_cycles", cnt_en,   1);
        check("load_busy",      cnt_busy, 2);
        check("load_done",      cnt_done, 1);
        check("load_ds",        int'(ds_cnt), 8'h5A);
        check("load_ready",     int'(cmd_if.CmdReady), 1);

        // LOAD 0x10 then UP 3
        issue(OP_LOAD, 8'h10, 1'b0);
        issue(OP_UP, 8'd3, 1'b0);
        check("up3_en_cycles", cnt_en,   3);
        check("up3_busy",      cnt_busy, 4);
        check("up3_ds",        int'(ds_cnt), 8'h13);
        check("up3_model",     int'(model_cnt), 8'h13);

        // DOWN 0 and NOP
        issue(OP_DOWN, 8'd0, 1'b0);
        check("down0_en",   cnt_en,   0);
        check("down0_busy", cnt_busy, 1);
        check("down0_done", cnt_done, 1);
        issue(OP_NOP, 8'h33, 1'b0);
        check("nop_en",   cnt_en,   0);
        check("nop_busy", cnt_busy, 1);
        check("nop_done", cnt_done, 1);

        // Reset on the 2nd STEP cycle of UP 10
        clr_counts();
        cmd_if.CmdValid = 1'b1;
        cmd_if.CmdOp    = OP_UP;
        cmd_if.CmdArg   = 8'd10;
        begin
            int m;
            @(posedge Clock); #1;
            build(OP_UP, 8'd10, m);
        end
        cmd_if.CmdValid = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        exp_q.delete();
        model_last = 8'h00;
        model_cnt  = 8'h00;
        check("abort_en",    int'(Enable), 0);
        check("abort_data",  int'(Data),   0);
        check("abort_ready", int'(cmd_if.CmdReady), 1);
        repeat (3) @(posedge Clock);
        #1;
        check("abort_no_done", cnt_done, 0);
        check("abort_en_cycles", cnt_en, 2);

        // LOAD 0xFE then UP 5 (saturation boundary)
        issue(OP_LOAD, 8'hFE, 1'b0);
        issue(OP_UP, 8'd5, 1'b0);
`ifdef COUNTER_SEQ_SAT_EN
        check("sat_up_en",    cnt_en,   1);
        check("sat_up_sat",   cnt_sat,  1);
        check("sat_up_busy",  cnt_busy, 3);
        check("sat_up_ds",    int'(ds_cnt),    8'hFF);
        check("sat_up_model", int'(model_cnt), 8'hFF);
`else
        check("wrap_up_en",    cnt_en,   5);
        check("wrap_up_sat",   cnt_sat,  0);
        check("wrap_up_busy",  cnt_busy, 6);
        check("wrap_up_ds",    int'(ds_cnt),    8'h03);
        check("wrap_up_model", int'(model_cnt), 8'h03);
`endif

        // UP 4 with CmdValid held and junk ops while busy, then LOAD 0x44
        issue(OP_LOAD, 8'h20, 1'b0);
        issue(OP_UP, 8'd4, 1'b1);
        check("hold_en_cycles", cnt_en,   4);
        check("hold_busy",      cnt_busy, 5);
        check("hold_ds",        int'(ds_cnt), 8'h24);
        issue(OP_LOAD, 8'h44, 1'b0);
        check("after_hold_ds", int'(ds_cnt), 8'h44);

        // Maximum step count
        issue(OP_LOAD, 8'hFF, 1'b0);
        issue(OP_DOWN, 8'd255, 1'b0);
        check("max_en_cycles", cnt_en,   255);
        check("max_busy",      cnt_busy, 256);
        check("max_ds",        int'(ds_cnt), 8'h00);
        check("max_sat",       cnt_sat,  0);

        // LOAD 0x02 then DOWN 4 (underflow boundary)
        issue(OP_LOAD, 8'h02, 1'b0);
        issue(OP_DOWN, 8'd4, 1'b0);
`ifdef COUNTER_SEQ_SAT_EN
        check("sat_dn_en",   cnt_en,   2);
        check("sat_dn_sat",  cnt_sat,  1);
        check("sat_dn_busy", cnt_busy, 4);
        check("sat_dn_ds",   int'(ds_cnt), 8'h00);
`else
        check("wrap_dn_en",   cnt_en,   4);
        check("wrap_dn_sat",  cnt_sat,  0);
        check("wrap_dn_busy", cnt_busy, 5);
        check("wrap_dn_ds",   int'(ds_cnt), 8'hFE);
`endif

        repeat (2) @(posedge Clock);
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
